// File: rtl/bcd_display_scan.sv
// -----------------------------------------------------------------------------
// bcd_display_scan
//
// Purpose:
//   Scans a 4-digit multiplexed common-anode seven-segment display from a BCD
//   hours/minutes pair. Both inputs are snapshotted once per frame, so a
//   single frame never mixes digits from two different values. The block also
//   provides per-pair blinking for setting mode and a blinking separator dot.
//
// Parameters:
//   SCAN_DIV     - clk cycles per digit slot (>= 2)
//   BLINK_FRAMES - full frames per blink half-period (>= 1)
//
// Optional feature:
//   BCD_DISPLAY_SCAN_LZB_EN - when defined, digit 3 (hours tens) is blanked
//                             when it is zero. Its anode is still driven low.
//
// Ports:
//   clk       in   system clock, rising edge
//   reset     in   synchronous, active-high
//   hours     in   [7:4] tens, [3:0] units (BCD)
//   minutes   in   [7:4] tens, [3:0] units (BCD)
//   blink_sel in   bit1 blinks hours pair, bit0 blinks minutes pair
//   colon_en  in   enables the blinking separator dot
//   seg       out  {g,f,e,d,c,b,a}, active-high, registered
//   an        out  digit enables, active-low, an[k] = digit k, registered
//   dp        out  decimal point, active-high, registered
// -----------------------------------------------------------------------------
module bcd_display_scan #(
  parameter int SCAN_DIV     = 50000,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] hours,
  input  logic [7:0] minutes,
  input  logic [1:0] blink_sel,
  input  logic       colon_en,
  output logic [6:0] seg,
  output logic [3:0] an,
  output logic       dp
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_MAX = PW'(SCAN_DIV - 1);
  localparam logic [FW-1:0] FRM_MAX = FW'(BLINK_FRAMES - 1);

  logic [PW-1:0] pre_r;
  logic [1:0]    idx_r;
  logic [FW-1:0] frm_r;
  logic          blink_phase_r;
  logic [15:0]   snap_r;
  logic          primed_r;

  logic          tick_s;
  logic          frame_end_s;
  logic          frame_start_s;
  logic [3:0]    nib_s;
  logic          blank_s;
  logic          lzb_s;
  logic [6:0]    seg_next_s;
  logic [3:0]    an_next_s;
  logic          dp_next_s;

  // BCD to segment pattern; any non-decimal nibble shows a dash.
  function automatic logic [6:0] decode7(input logic [3:0] n);
    case (n)
      4'd0:    decode7 = 7'h3F;
      4'd1:    decode7 = 7'h06;
      4'd2:    decode7 = 7'h5B;
      4'd3:    decode7 = 7'h4F;
      4'd4:    decode7 = 7'h66;
      4'd5:    decode7 = 7'h6D;
      4'd6:    decode7 = 7'h7D;
      4'd7:    decode7 = 7'h07;
      4'd8:    decode7 = 7'h7F;
      4'd9:    decode7 = 7'h6F;
      default: decode7 = 7'h40;
    endcase
  endfunction

  assign tick_s        = (pre_r == PRE_MAX);
  assign frame_end_s   = tick_s && (idx_r == 2'd3);
  // The first cycle out of reset primes the snapshot; later frames start
  // when the last digit slot expires.
  assign frame_start_s = !primed_r || frame_end_s;

  // Select the snapshot nibble for the digit currently being scanned.
  always_comb begin
    nib_s = snap_r[3:0];
    case (idx_r)
      2'd0:    nib_s = snap_r[3:0];
      2'd1:    nib_s = snap_r[7:4];
      2'd2:    nib_s = snap_r[11:8];
      2'd3:    nib_s = snap_r[15:12];
      default: nib_s = snap_r[3:0];
    endcase
  end

  // Blink blanking, leading-zero blanking and next-output computation.
  always_comb begin
    blank_s = 1'b0;
    lzb_s   = 1'b0;
    if (idx_r[1]) begin
      blank_s = blink_sel[1] && blink_phase_r;
    end else begin
      blank_s = blink_sel[0] && blink_phase_r;
    end
`ifdef BCD_DISPLAY_SCAN_LZB_EN
    lzb_s = (idx_r == 2'd3) && (snap_r[15:12] == 4'h0);
`else
    lzb_s = 1'b0;
`endif
    if (blank_s || lzb_s) begin
      seg_next_s = 7'h00;
    end else begin
      seg_next_s = decode7(nib_s);
    end
    an_next_s = ~(4'b0001 << idx_r);
    dp_next_s = (idx_r == 2'd2) && colon_en && !blink_phase_r;
  end

  // Scan counters, frame snapshot, blink timing and registered outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      pre_r         <= '0;
      idx_r         <= 2'd0;
      frm_r         <= '0;
      blink_phase_r <= 1'b0;
      snap_r        <= 16'h0000;
      primed_r      <= 1'b0;
      seg           <= 7'h00;
      an            <= 4'b1111;
      dp            <= 1'b0;
    end else begin
      if (tick_s) begin
        pre_r <= '0;
        idx_r <= idx_r + 2'd1;
      end else begin
        pre_r <= pre_r + PW'(1);
      end
      if (frame_start_s) begin
        snap_r <= {hours, minutes};
      end
      primed_r <= 1'b1;
      // The priming start is not counted toward the blink period.
      if (primed_r && frame_end_s) begin
        if (frm_r == FRM_MAX) begin
          frm_r         <= '0;
          blink_phase_r <= !blink_phase_r;
        end else begin
          frm_r <= frm_r + FW'(1);
        end
      end
      seg <= seg_next_s;
      an  <= an_next_s;
      dp  <= dp_next_s;
    end
  end

endmodule
